// File: rtl/health_pkg.sv
// Shared definitions for the health manager and the health-bar display.
package health_pkg;

   localparam int HEALTH_W = 4;
   localparam logic [HEALTH_W-1:0] DEFAULT_HEALTH = 4'd3;

   typedef enum logic [1:0] {
      ALIVE  = 2'd0,
      INVULN = 2'd1,
      DEAD   = 2'd2
   } state_t;

endpackage

// File: rtl/invuln_timer.sv
// Post-hit invulnerability down-counter with a frame-tick blink divider.
module invuln_timer #(
   parameter int INVULN_FRAMES = 60,
   parameter int BLINK_FRAMES  = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic clear,
   input  logic tick,
   output logic done,
   output logic blink
);

   localparam int CW = $clog2(INVULN_FRAMES + 1);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [CW-1:0] LOAD_VAL  = CW'(INVULN_FRAMES);
   localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_FRAMES - 1);

   logic [CW-1:0] count;
   logic [BW-1:0] blink_count;

   // Load and clear win over tick, so a tick in the loading cycle is not counted.
   assign done = tick && !load && !clear && (count == CW'(1));

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count       <= '0;
         blink_count <= '0;
         blink       <= 1'b0;
      end else if (clear) begin
         count       <= '0;
         blink_count <= '0;
         blink       <= 1'b0;
      end else if (load) begin
         count       <= LOAD_VAL;
         blink_count <= '0;
         blink       <= 1'b1;
      end else if (tick && count != '0) begin
         count <= count - CW'(1);
         if (count == CW'(1)) begin
            blink_count <= '0;
            blink       <= 1'b0;
         end else if (blink_count == BLINK_TOP) begin
            blink_count <= '0;
            blink       <= ~blink;
         end else begin
            blink_count <= blink_count + BW'(1);
         end
      end
   end

endmodule

// File: rtl/health_manager.sv
// Player health FSM: damage, healing, post-hit invulnerability and game over.
module health_manager
   import health_pkg::*;
#(
   parameter int MAX_HEALTH    = int'(DEFAULT_HEALTH),
   parameter int INVULN_FRAMES = 60,
   parameter int BLINK_FRAMES  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_tick,
   input  logic                hit,
   input  logic                heal,
   input  logic                restart,
   output logic [HEALTH_W-1:0] present_health,
   output logic                invulnerable,
   output logic                blink,
   output logic                game_over,
   output logic                damage_taken
);

   localparam logic [HEALTH_W-1:0] MAX_H = HEALTH_W'(MAX_HEALTH);

   state_t state;
   logic   timer_load;
   logic   timer_tick;
   logic   timer_done;

   assign timer_load = (state == ALIVE) && hit && !restart && (present_health > HEALTH_W'(1));
   assign timer_tick = (state == INVULN) && frame_tick;

   invuln_timer #(
      .INVULN_FRAMES (INVULN_FRAMES),
      .BLINK_FRAMES  (BLINK_FRAMES)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (timer_load),
      .clear (restart),
      .tick  (timer_tick),
      .done  (timer_done),
      .blink (blink)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ALIVE;
         present_health <= MAX_H;
         invulnerable   <= 1'b0;
         game_over      <= 1'b0;
         damage_taken   <= 1'b0;
      end else begin
         damage_taken <= 1'b0;
         if (restart) begin
            state          <= ALIVE;
            present_health <= MAX_H;
            invulnerable   <= 1'b0;
            game_over      <= 1'b0;
         end else begin
            case (state)
               ALIVE: begin
                  // A hit discards any heal in the same cycle.
                  if (hit) begin
                     damage_taken <= 1'b1;
                     if (present_health > HEALTH_W'(1)) begin
                        present_health <= present_health - HEALTH_W'(1);
                        state          <= INVULN;
                        invulnerable   <= 1'b1;
                     end else begin
                        present_health <= '0;
                        state          <= DEAD;
                        game_over      <= 1'b1;
                     end
                  end else if (heal && present_health < MAX_H) begin
                     present_health <= present_health + HEALTH_W'(1);
                  end
               end
               INVULN: begin
                  if (heal && present_health < MAX_H)
                     present_health <= present_health + HEALTH_W'(1);
                  if (timer_done) begin
                     state        <= ALIVE;
                     invulnerable <= 1'b0;
                  end
               end
               DEAD: begin
                  present_health <= '0;
               end
               default: begin
                  state          <= ALIVE;
                  present_health <= MAX_H;
                  invulnerable   <= 1'b0;
                  game_over      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_health_manager.sv
// Scoreboard bench for health_manager with hand-computed directed vectors.
module tb_health_manager;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       frame_tick = 1'b0;
   logic       hit = 1'b0;
   logic       heal = 1'b0;
   logic       restart = 1'b0;
   logic [3:0] present_health;
   logic       invulnerable;
   logic       blink;
   logic       game_over;
   logic       damage_taken;

   typedef struct {
      string      name;
      int         cyc;
      logic [3:0] h;
      logic       inv;
      logic       blk;
      logic       go;
      logic       dmg;
   } exp_t;

   exp_t q[$];
   int   cyc_cnt = 0;
   int   n_vec = 0;
   int   n_err = 0;
   event chk_ev;

   health_manager #(
      .MAX_HEALTH    (3),
      .INVULN_FRAMES (60),
      .BLINK_FRAMES  (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .frame_tick     (frame_tick),
      .hit            (hit),
      .heal           (heal),
      .restart        (restart),
      .present_health (present_health),
      .invulnerable   (invulnerable),
      .blink          (blink),
      .game_over      (game_over),
      .damage_taken   (damage_taken)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input exp_t e);
      n_vec++;
      if (present_health !== e.h || invulnerable !== e.inv || blink !== e.blk ||
          game_over !== e.go || damage_taken !== e.dmg) begin
         n_err++;
         $display("FAIL %s: got h=%0d inv=%b blink=%b go=%b dmg=%b, want h=%0d inv=%b blink=%b go=%b dmg=%b",
                  e.name, present_health, invulnerable, blink, game_over, damage_taken,
                  e.h, e.inv, e.blk, e.go, e.dmg);
      end
   endtask

   // Monitor: pops every expectation whose cycle has come due.
   initial begin
      forever begin
         @(negedge clk or chk_ev);
         while (q.size() > 0 && q[0].cyc <= cyc_cnt) check(q.pop_front());
      end
   end

   task automatic drive(input logic h, input logic hl, input logic rs, input logic tk);
      @(posedge clk);
      #1;
      hit = h; heal = hl; restart = rs; frame_tick = tk;
   endtask

   task automatic expect_out(input string n, input int dly, input logic [3:0] eh,
                             input logic ei, input logic eb, input logic eg, input logic ed);
      exp_t e;
      e.name = n; e.cyc = cyc_cnt + dly;
      e.h = eh; e.inv = ei; e.blk = eb; e.go = eg; e.dmg = ed;
      q.push_back(e);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d expectations still pending, want 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values while rst is held low
      drive(0, 0, 0, 0);
      expect_out("reset", 0, 4'd3, 0, 0, 0, 0);
      drive(0, 0, 0, 0);
      rst = 1'b1;

      // First hit after reset
      drive(1, 0, 0, 0);
      expect_out("hit1", 1, 4'd2, 1, 1, 0, 1);
      drive(0, 0, 0, 0);
      expect_out("dmg_once", 1, 4'd2, 1, 1, 0, 0);

      // Hit on every frame tick through the whole window
      for (int k = 1; k <= 60; k++) begin
         drive(1, 0, 0, 1);
         expect_out($sformatf("invuln_tick%0d", k), 1, 4'd2, k < 60,
                    (k < 60) ? (((k / 8) % 2) == 0) : 1'b0, 0, 0);
      end

      // Heal, saturate, then hit+heal in ALIVE and in INVULN
      drive(0, 1, 0, 0);
      expect_out("heal_to3", 1, 4'd3, 0, 0, 0, 0);
      drive(0, 1, 0, 0);
      expect_out("heal_sat", 1, 4'd3, 0, 0, 0, 0);
      drive(1, 1, 0, 0);
      expect_out("alive_hit_wins", 1, 4'd2, 1, 1, 0, 1);
      drive(1, 1, 0, 0);
      expect_out("invuln_heal_wins", 1, 4'd3, 1, 1, 0, 0);
      for (int k = 1; k <= 60; k++) begin
         drive(0, 0, 0, 1);
         if (k == 59) expect_out("heal_win_t59", 1, 4'd3, 1, 0, 0, 0);
         if (k == 60) expect_out("heal_win_t60", 1, 4'd3, 0, 0, 0, 0);
      end

      // Death: hit coinciding with a tick does not shorten the window
      drive(1, 0, 0, 1);
      expect_out("death_hit1", 1, 4'd2, 1, 1, 0, 1);
      for (int k = 1; k <= 60; k++) begin
         drive(0, 0, 0, 1);
         if (k == 59) expect_out("load_tick_t59", 1, 4'd2, 1, 0, 0, 0);
         if (k == 60) expect_out("load_tick_t60", 1, 4'd2, 0, 0, 0, 0);
      end
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      expect_out("alive_gap1", 1, 4'd2, 0, 0, 0, 0);
      drive(1, 0, 0, 0);
      expect_out("death_hit2", 1, 4'd1, 1, 1, 0, 1);
      for (int k = 1; k <= 60; k++) begin
         drive(0, 0, 0, 1);
         if (k == 60) expect_out("hit2_t60", 1, 4'd1, 0, 0, 0, 0);
      end
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      drive(1, 0, 0, 0);
      expect_out("death_hit3", 1, 4'd0, 0, 0, 1, 1);
      drive(1, 0, 0, 0);
      expect_out("dead_hit", 1, 4'd0, 0, 0, 1, 0);
      drive(0, 1, 0, 0);
      expect_out("dead_heal", 1, 4'd0, 0, 0, 1, 0);
      drive(0, 0, 0, 1);
      expect_out("dead_tick", 1, 4'd0, 0, 0, 1, 0);

      // Restart beats a simultaneous hit and tick
      drive(1, 0, 1, 1);
      expect_out("restart", 1, 4'd3, 0, 0, 0, 0);
      drive(0, 0, 0, 0);
      expect_out("restart_no_dmg", 1, 4'd3, 0, 0, 0, 0);

      // Asynchronous reset in the middle of INVULN
      drive(1, 0, 0, 0);
      expect_out("pre_async_hit", 1, 4'd2, 1, 1, 0, 1);
      for (int k = 1; k <= 12; k++) begin
         drive(0, 0, 0, 1);
         if (k == 12) expect_out("pre_async_t12", 1, 4'd2, 1, 0, 0, 0);
      end
      drive(0, 0, 0, 0);
      wait_drain();
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      expect_out("async_reset", 0, 4'd3, 0, 0, 0, 0);
      -> chk_ev;
      drive(0, 0, 0, 0);
      rst = 1'b1;
      drive(1, 0, 0, 0);
      expect_out("post_reset_hit", 1, 4'd2, 1, 1, 0, 1);
      for (int k = 1; k <= 59; k++) begin
         drive(0, 0, 0, 1);
         if (k == 59) expect_out("post_reset_t59", 1, 4'd2, 1, 0, 0, 0);
      end
      drive(0, 0, 0, 0);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/health_manager.md
HEALTH_MANAGER -- requirements
Module: health_manager

Interface
REQ-001 The block SHALL have parameter MAX_HEALTH, default 3: health on reset and restart; legal range 1..15.
REQ-002 The block SHALL have parameter INVULN_FRAMES, default 60: length of the post-hit invulnerability window, counted in frame ticks.
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 8: frame ticks per half-period of the blink output.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port frame_tick, input, 1 bit: one-cycle pulse, once per video frame.
REQ-007 The block SHALL have port hit, input, 1 bit: one-cycle damage request.
REQ-008 The block SHALL have port heal, input, 1 bit: one-cycle heal request.
REQ-009 The block SHALL have port restart, input, 1 bit: one-cycle new-game request.
REQ-010 The block SHALL have port present_health, output, 4 bits: registered health count for the health-bar display.
REQ-011 The block SHALL have port invulnerable, output, 1 bit: high while in the INVULN state.
REQ-012 The block SHALL have port blink, output, 1 bit: display flash enable; toggles during INVULN.
REQ-013 The block SHALL have port game_over, output, 1 bit: high while in the DEAD state.
REQ-014 The block SHALL have port damage_taken, output, 1 bit: one-cycle pulse, asserted the cycle after an accepted hit.

Function
REQ-015 The FSM SHALL have exactly three states: ALIVE, INVULN and DEAD.
REQ-016 In ALIVE, a hit with health > 1 SHALL decrement health, load the frame counter with INVULN_FRAMES and enter INVULN.
REQ-017 In ALIVE, a hit with health == 1 SHALL set health to 0 and enter DEAD.
REQ-018 In INVULN, hit SHALL be ignored: no health change and no damage_taken pulse.
REQ-019 In INVULN, each frame_tick SHALL decrement the counter; the tick that takes the counter from 1 to 0 SHALL return the FSM to ALIVE on the next clk.
REQ-020 In ALIVE or INVULN, heal SHALL increment health, saturating at MAX_HEALTH; a heal at MAX_HEALTH SHALL be a no-op.
REQ-021 In ALIVE, hit and heal in the same cycle SHALL apply the hit only; the heal is discarded.
REQ-022 In INVULN, hit and heal in the same cycle SHALL apply the heal only.
REQ-023 In DEAD, hit, heal and frame_tick SHALL be ignored; health SHALL stay 0.
REQ-024 restart in any state SHALL load health = MAX_HEALTH, clear the counter and blink, and enter ALIVE; restart SHALL take priority over hit, heal and frame_tick in the same cycle.
REQ-025 Every output SHALL be registered; state and health changes SHALL be visible one clk after the triggering input.
REQ-026 blink SHALL be 0 outside INVULN; on entry to INVULN it SHALL be 1 and toggle every BLINK_FRAMES frame ticks.
REQ-027 A frame_tick in the same cycle as the hit that enters INVULN SHALL NOT decrement the newly loaded counter.
REQ-028 Counter width SHALL be clog2(INVULN_FRAMES+1); the counter SHALL never underflow.

Reset
REQ-029 While rst is low, the block SHALL asynchronously force state = ALIVE, present_health = MAX_HEALTH, and counters, invulnerable, blink, game_over and damage_taken to 0.
REQ-030 Reset asserted mid-INVULN or mid-DEAD SHALL discard all progress; operation SHALL resume from the first clk edge after rst goes high.

Structure
REQ-031 The state enum, a default-health constant and the health width (4) SHALL reside in a shared package, health_pkg, which the display side also imports.
REQ-032 The frame-tick down-counter and blink divider SHALL be one sub-module, invuln_timer, with load, tick, count-done and blink outputs.

Verification
REQ-033 Bench SHALL check reset: release rst, then hit -> present_health 3->2, damage_taken pulses once, invulnerable=1, blink=1.
REQ-034 Bench SHALL check invulnerability: hit every frame for 60 frame_ticks after the first hit -> health stays 2, invulnerable drops exactly after the 60th tick, and blink toggles every 8 ticks.
REQ-035 Bench SHALL check death: three hits spaced more than 60 frames apart -> health 3->2->1->0, game_over=1; a further hit or heal leaves health at 0.
REQ-036 Bench SHALL check heal: at health 2 in ALIVE, heal -> 3; heal again -> 3 (saturated); a simultaneous hit and heal at 3 -> 2 (hit wins).
REQ-037 Bench SHALL check restart: restart in DEAD together with hit -> health 3, state ALIVE, game_over=0, no damage_taken pulse.
REQ-038 Bench SHALL check asynchronous reset: pull rst low mid-INVULN between clock edges -> outputs reach reset values immediately, without waiting for a clk edge.
